// File: rtl/mem_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mem_port_arbiter                                             |
// | Description : Shares one single-ported memory between instruction fetch   |
// |               and the load/store unit. One transaction is outstanding at a |
// |               time. The LSU has priority, limited by a streak counter so   |
// |               fetch always makes progress. A fetch redirect can drop an    |
// |               in-flight fetch response. Optional statistics counters are   |
// |               enabled by defining ARB_STATS_EN.                            |
// | Revision    : 1.0 - initial release                                       |
// +----------------------------------------------------------------------------+
module mem_port_arbiter #(
    parameter int ADDR_W        = 32,
    parameter int DATA_W        = 32,
    parameter int MAX_LS_STREAK = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req,
    input  logic [ADDR_W-1:0]     if_addr,
    input  logic                  if_flush,
    output logic                  if_gnt,
    output logic                  if_rvalid,
    output logic [DATA_W-1:0]     if_rdata,
    input  logic                  ls_req,
    input  logic                  ls_we,
    input  logic [ADDR_W-1:0]     ls_addr,
    input  logic [DATA_W-1:0]     ls_wdata,
    input  logic [DATA_W/8-1:0]   ls_be,
    output logic                  ls_gnt,
    output logic                  ls_rvalid,
    output logic [DATA_W-1:0]     ls_rdata,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W/8-1:0]   mem_be,
    input  logic                  mem_gnt,
    input  logic                  mem_rvalid,
    input  logic [DATA_W-1:0]     mem_rdata
`ifdef ARB_STATS_EN
    ,
    output logic [31:0]           stat_conflicts,
    output logic [31:0]           stat_if_stall
`endif
);

    localparam int         c_BE_W       = DATA_W / 8;
    localparam logic [1:0] c_S_IDLE     = 2'd0;
    localparam logic [1:0] c_S_REQ      = 2'd1;
    localparam logic [1:0] c_S_WAIT     = 2'd2;
    localparam logic [1:0] c_OWN_NONE   = 2'd0;
    localparam logic [1:0] c_OWN_IF     = 2'd1;
    localparam logic [1:0] c_OWN_LS     = 2'd2;
    localparam logic [3:0] c_STREAK_MAX = 4'(MAX_LS_STREAK);

    logic [1:0]        r_state, w_state_nxt;
    logic [1:0]        r_owner, w_owner_nxt;
    logic [3:0]        r_streak, w_streak_nxt;
    logic              r_drop, w_drop_nxt;
    logic              r_mem_req, w_mem_req_nxt;
    logic              r_mem_we, w_mem_we_nxt;
    logic [ADDR_W-1:0] r_mem_addr, w_mem_addr_nxt;
    logic [DATA_W-1:0] r_mem_wdata, w_mem_wdata_nxt;
    logic [c_BE_W-1:0] r_mem_be, w_mem_be_nxt;
    logic [DATA_W-1:0] r_if_rdata, r_ls_rdata;
    logic              w_if_gnt, w_ls_gnt, w_if_rvalid, w_ls_rvalid;
    logic              w_ls_wins;

    always_comb begin
        w_state_nxt     = r_state;
        w_owner_nxt     = r_owner;
        w_streak_nxt    = r_streak;
        w_drop_nxt      = r_drop;
        w_mem_req_nxt   = r_mem_req;
        w_mem_we_nxt    = r_mem_we;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_wdata_nxt = r_mem_wdata;
        w_mem_be_nxt    = r_mem_be;
        w_if_gnt        = 1'b0;
        w_ls_gnt        = 1'b0;
        w_if_rvalid     = 1'b0;
        w_ls_rvalid     = 1'b0;
        w_ls_wins       = ls_req && (!if_req || (r_streak < c_STREAK_MAX));

        case (r_state)
            c_S_IDLE: begin
                if (!if_req) begin
                    w_streak_nxt = '0;
                end
                if (if_req || ls_req) begin
                    w_state_nxt   = c_S_REQ;
                    w_mem_req_nxt = 1'b1;
                    if (w_ls_wins) begin
                        w_owner_nxt     = c_OWN_LS;
                        w_mem_we_nxt    = ls_we;
                        w_mem_addr_nxt  = ls_addr;
                        w_mem_wdata_nxt = ls_wdata;
                        w_mem_be_nxt    = ls_be;
                    end else begin
                        w_owner_nxt     = c_OWN_IF;
                        w_mem_we_nxt    = 1'b0;
                        w_mem_addr_nxt  = if_addr;
                        w_mem_wdata_nxt = '0;
                        w_mem_be_nxt    = '1;
                    end
                end
            end
            c_S_REQ: begin
                if ((r_owner == c_OWN_IF) && if_flush) begin
                    w_drop_nxt = 1'b1;
                end
                if (mem_gnt) begin
                    w_mem_req_nxt = 1'b0;
                    w_state_nxt   = c_S_WAIT;
                    if (r_owner == c_OWN_LS) begin
                        w_ls_gnt = 1'b1;
                        // Only LSU wins taken at fetch's expense count toward the limit.
                        if (if_req) begin
                            w_streak_nxt = (r_streak >= c_STREAK_MAX) ? c_STREAK_MAX
                                                                      : r_streak + 4'd1;
                        end
                    end else begin
                        w_if_gnt     = 1'b1;
                        w_streak_nxt = '0;
                    end
                end
            end
            c_S_WAIT: begin
                if ((r_owner == c_OWN_IF) && if_flush) begin
                    w_drop_nxt = 1'b1;
                end
                if (mem_rvalid) begin
                    if (r_owner == c_OWN_LS) begin
                        w_ls_rvalid = 1'b1;
                    end else begin
                        w_if_rvalid = !r_drop && !if_flush;
                    end
                    w_state_nxt = c_S_IDLE;
                    w_owner_nxt = c_OWN_NONE;
                    w_drop_nxt  = 1'b0;
                end
            end
            default: begin
                w_state_nxt   = c_S_IDLE;
                w_owner_nxt   = c_OWN_NONE;
                w_mem_req_nxt = 1'b0;
                w_drop_nxt    = 1'b0;
            end
        endcase

        if (rst) begin
            w_if_gnt    = 1'b0;
            w_ls_gnt    = 1'b0;
            w_if_rvalid = 1'b0;
            w_ls_rvalid = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_S_IDLE;
            r_owner     <= c_OWN_NONE;
            r_streak    <= '0;
            r_drop      <= 1'b0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_be    <= '0;
            r_if_rdata  <= '0;
            r_ls_rdata  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_owner     <= w_owner_nxt;
            r_streak    <= w_streak_nxt;
            r_drop      <= w_drop_nxt;
            r_mem_req   <= w_mem_req_nxt;
            r_mem_we    <= w_mem_we_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
            r_mem_be    <= w_mem_be_nxt;
            if (w_if_rvalid) begin
                r_if_rdata <= mem_rdata;
            end
            if (w_ls_rvalid) begin
                r_ls_rdata <= mem_rdata;
            end
        end
    end

    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_be    = r_mem_be;
    assign if_gnt    = w_if_gnt;
    assign ls_gnt    = w_ls_gnt;
    assign if_rvalid = w_if_rvalid;
    assign ls_rvalid = w_ls_rvalid;
    // Read data passes straight through on the response cycle, then holds.
    assign if_rdata  = rst ? '0 : (w_if_rvalid ? mem_rdata : r_if_rdata);
    assign ls_rdata  = rst ? '0 : (w_ls_rvalid ? mem_rdata : r_ls_rdata);

`ifdef ARB_STATS_EN
    logic [31:0] r_stat_conflicts;
    logic [31:0] r_stat_if_stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat_conflicts <= '0;
            r_stat_if_stall  <= '0;
        end else begin
            if ((r_state == c_S_IDLE) && if_req && ls_req && (r_stat_conflicts != '1)) begin
                r_stat_conflicts <= r_stat_conflicts + 32'd1;
            end
            if (if_req && !w_if_gnt && (r_stat_if_stall != '1)) begin
                r_stat_if_stall <= r_stat_if_stall + 32'd1;
            end
        end
    end

    assign stat_conflicts = r_stat_conflicts;
    assign stat_if_stall  = r_stat_if_stall;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_mem_port_arbiter                                          |
// | Description : Directed self-checking bench for mem_port_arbiter.           |
// | Revision    : 1.0 - initial release                                       |
// +----------------------------------------------------------------------------+
module tb_mem_port_arbiter;

    localparam int c_ADDR_W = 32;
    localparam int c_DATA_W = 32;
    localparam int c_BE_W   = c_DATA_W / 8;

    logic                clk = 1'b0;
    logic                rst;
    logic                if_req, if_flush, if_gnt, if_rvalid;
    logic [c_ADDR_W-1:0] if_addr;
    logic [c_DATA_W-1:0] if_rdata;
    logic                ls_req, ls_we, ls_gnt, ls_rvalid;
    logic [c_ADDR_W-1:0] ls_addr;
    logic [c_DATA_W-1:0] ls_wdata, ls_rdata;
    logic [c_BE_W-1:0]   ls_be;
    logic                mem_req, mem_we, mem_gnt, mem_rvalid;
    logic [c_ADDR_W-1:0] mem_addr;
    logic [c_DATA_W-1:0] mem_wdata, mem_rdata;
    logic [c_BE_W-1:0]   mem_be;
`ifdef ARB_STATS_EN
    logic [31:0]         stat_conflicts, stat_if_stall;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W(c_ADDR_W), .DATA_W(c_DATA_W), .MAX_LS_STREAK(4)
    ) u_dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_be(ls_be), .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
`ifdef ARB_STATS_EN
        ,
        .stat_conflicts(stat_conflicts), .stat_if_stall(stat_if_stall)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        if_req = 1'b0; if_addr = '0; if_flush = 1'b0;
        ls_req = 1'b0; ls_we = 1'b0; ls_addr = '0; ls_wdata = '0; ls_be = '0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [c_DATA_W-1:0] got_rd;
        rst = 1'b1;
        idle_inputs();
        if_req = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        tick();
        tick();
        @(negedge clk);
        n_checks++;
        if ({mem_req, mem_we, mem_addr, mem_wdata, mem_be, if_gnt, if_rvalid, ls_gnt, ls_rvalid} !== '0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got req=%b we=%b addr=%h wdata=%h be=%h ig=%b iv=%b lg=%b lv=%b expected all 0",
                     mem_req, mem_we, mem_addr, mem_wdata, mem_be, if_gnt, if_rvalid, ls_gnt, ls_rvalid);
        end
        n_checks++;
        if ({if_rdata, ls_rdata} !== 64'h0) begin
            n_fail++;
            $display("FAIL reset_rdata: got if=%h ls=%h expected 0", if_rdata, ls_rdata);
        end
        tick();
        rst = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        if_req = 1'b1; if_addr = 32'h0; mem_gnt = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({mem_req, if_gnt} !== 2'b00) begin
            n_fail++;
            $display("FAIL first_c0: got req=%b gnt=%b expected 0 0", mem_req, if_gnt);
        end
        tick();
        @(negedge clk);
        n_checks++;
        if ({mem_req, mem_we, mem_addr, mem_be, if_gnt, ls_gnt} !== {1'b1, 1'b0, 32'h0, 4'hF, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL first_c1: got req=%b we=%b addr=%h be=%h ig=%b lg=%b expected 1 0 0 f 1 0",
                     mem_req, mem_we, mem_addr, mem_be, if_gnt, ls_gnt);
        end
        tick();
        if_req = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0000_0013;
        @(negedge clk);
        n_checks++;
        if ({if_rvalid, if_rdata, mem_req, if_gnt} !== {1'b1, 32'h13, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL first_c2: got rv=%b rd=%h req=%b gnt=%b expected 1 13 0 0", if_rvalid, if_rdata, mem_req, if_gnt);
        end
        tick();
        mem_rvalid = 1'b0; mem_rdata = 32'h5555_AAAA;
        @(negedge clk);
        got_rd = if_rdata;
        n_checks++;
        if ({if_rvalid, got_rd} !== {1'b0, 32'h13}) begin
            n_fail++;
            $display("FAIL first_hold: got rv=%b rd=%h expected 0 13", if_rvalid, got_rd);
        end
    endtask

    task automatic test_priority();
        logic e_if;
        do_reset();
        if_req = 1'b1; if_addr = 32'h1000;
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h2000; ls_be = 4'hF;
        mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h77;
        for (int t = 0; t < 10; t++) begin
            e_if = (t % 5 == 4);
            @(negedge clk);
            n_checks++;
            if ({mem_req, if_gnt, ls_gnt} !== 3'b000) begin
                n_fail++;
                $display("FAIL prio_idle[%0d]: got req=%b ig=%b lg=%b expected 000", t, mem_req, if_gnt, ls_gnt);
            end
            tick();
            @(negedge clk);
            n_checks++;
            if ({if_gnt, ls_gnt, mem_addr} !== {e_if, ~e_if, (e_if ? 32'h1000 : 32'h2000)}) begin
                n_fail++;
                $display("FAIL prio_gnt[%0d]: got ig=%b lg=%b addr=%h expected ig=%b", t, if_gnt, ls_gnt, mem_addr, e_if);
            end
            tick();
            @(negedge clk);
            n_checks++;
            if ({if_rvalid, ls_rvalid} !== {e_if, ~e_if}) begin
                n_fail++;
                $display("FAIL prio_rv[%0d]: got iv=%b lv=%b expected iv=%b", t, if_rvalid, ls_rvalid, e_if);
            end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_store_stall();
        do_reset();
        ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h100; ls_wdata = 32'hDEAD_BEEF; ls_be = 4'b0011;
        @(negedge clk);
        n_checks++;
        if (mem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL st_c0: got req=%b expected 0", mem_req);
        end
        tick();
        for (int k = 1; k <= 4; k++) begin
            mem_gnt = (k == 4);
            @(negedge clk);
            n_checks++;
            if ({mem_req, mem_we, mem_addr, mem_wdata, mem_be, ls_gnt} !==
                {1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF, 4'b0011, (k == 4)}) begin
                n_fail++;
                $display("FAIL st_req[%0d]: got req=%b we=%b addr=%h wd=%h be=%b lg=%b expected 1 1 100 deadbeef 0011 %0d",
                         k, mem_req, mem_we, mem_addr, mem_wdata, mem_be, ls_gnt, (k == 4));
            end
            tick();
        end
        ls_req = 1'b0; mem_gnt = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({mem_req, ls_gnt, ls_rvalid} !== 3'b000) begin
            n_fail++;
            $display("FAIL st_wait: got req=%b lg=%b lv=%b expected 000", mem_req, ls_gnt, ls_rvalid);
        end
        tick();
        mem_rvalid = 1'b1;
        @(negedge clk);
        n_checks++;
        if (ls_rvalid !== 1'b1) begin
            n_fail++;
            $display("FAIL st_rv: got %b expected 1", ls_rvalid);
        end
        tick();
        mem_rvalid = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({ls_rvalid, mem_req} !== 2'b00) begin
            n_fail++;
            $display("FAIL st_after: got lv=%b req=%b expected 00", ls_rvalid, mem_req);
        end
        idle_inputs();
    endtask

    task automatic test_flush();
        do_reset();
        if_req = 1'b1; if_addr = 32'h40; mem_gnt = 1'b1;
        tick();
        @(negedge clk);
        n_checks++;
        if ({if_gnt, mem_addr} !== {1'b1, 32'h40}) begin
            n_fail++;
            $display("FAIL fl_gnt: got gnt=%b addr=%h expected 1 40", if_gnt, mem_addr);
        end
        tick();
        if_req = 1'b0; if_flush = 1'b1;
        tick();
        if_flush = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hBAD0_BAD0;
        @(negedge clk);
        n_checks++;
        if ({if_rvalid, if_rdata} !== {1'b0, 32'h0}) begin
            n_fail++;
            $display("FAIL fl_drop: got rv=%b rd=%h expected 0 0", if_rvalid, if_rdata);
        end
        tick();
        mem_rvalid = 1'b0; if_req = 1'b1; if_addr = 32'h80; if_flush = 1'b1;
        tick();
        if_flush = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({if_gnt, mem_addr} !== {1'b1, 32'h80}) begin
            n_fail++;
            $display("FAIL fl_next_gnt: got gnt=%b addr=%h expected 1 80", if_gnt, mem_addr);
        end
        tick();
        if_req = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h93;
        @(negedge clk);
        n_checks++;
        if ({if_rvalid, if_rdata} !== {1'b1, 32'h93}) begin
            n_fail++;
            $display("FAIL fl_next_rv: got rv=%b rd=%h expected 1 93", if_rvalid, if_rdata);
        end
        tick();
        mem_rvalid = 1'b0; if_req = 1'b1; if_addr = 32'hC0;
        tick();
        tick();
        if_req = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h1111; if_flush = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({if_rvalid, if_rdata} !== {1'b0, 32'h93}) begin
            n_fail++;
            $display("FAIL fl_same_cycle: got rv=%b rd=%h expected 0 93", if_rvalid, if_rdata);
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_reset_in_wait();
        do_reset();
        ls_req = 1'b1; ls_addr = 32'h200; mem_gnt = 1'b1;
        tick();
        @(negedge clk);
        n_checks++;
        if (ls_gnt !== 1'b1) begin
            n_fail++;
            $display("FAIL rw_gnt: got %b expected 1", ls_gnt);
        end
        tick();
        ls_req = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hAAAA_5555;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            n_checks++;
            if ({ls_rvalid, if_rvalid, ls_rdata, mem_req} !== {1'b0, 1'b0, 32'h0, 1'b0}) begin
                n_fail++;
                $display("FAIL rw_stale[%0d]: got lv=%b iv=%b lrd=%h req=%b expected 0 0 0 0",
                         k, ls_rvalid, if_rvalid, ls_rdata, mem_req);
            end
            tick();
        end
        mem_rvalid = 1'b0; ls_req = 1'b1; ls_addr = 32'h300;
        tick();
        @(negedge clk);
        n_checks++;
        if ({ls_gnt, mem_addr} !== {1'b1, 32'h300}) begin
            n_fail++;
            $display("FAIL rw_next_gnt: got gnt=%b addr=%h expected 1 300", ls_gnt, mem_addr);
        end
        tick();
        ls_req = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
        @(negedge clk);
        n_checks++;
        if ({ls_rvalid, ls_rdata} !== {1'b1, 32'h1234_5678}) begin
            n_fail++;
            $display("FAIL rw_next_rv: got rv=%b rd=%h expected 1 12345678", ls_rvalid, ls_rdata);
        end
        tick();
        idle_inputs();
    endtask

`ifdef ARB_STATS_EN
    task automatic test_stats();
        do_reset();
        if_req = 1'b1; if_addr = 32'h10; ls_req = 1'b1; ls_addr = 32'h20;
        mem_gnt = 1'b1; mem_rvalid = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({stat_conflicts, stat_if_stall} !== 64'h0) begin
            n_fail++;
            $display("FAIL stats_reset: got c=%0d s=%0d expected 0 0", stat_conflicts, stat_if_stall);
        end
        for (int k = 0; k < 10; k++) tick();
        idle_inputs();
        @(negedge clk);
        n_checks++;
        if ({stat_conflicts, stat_if_stall} !== {32'd4, 32'd10}) begin
            n_fail++;
            $display("FAIL stats_count: got c=%0d s=%0d expected 4 10", stat_conflicts, stat_if_stall);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_priority();
        test_store_stall();
        test_flush();
        test_reset_in_wait();
`ifdef ARB_STATS_EN
        test_stats();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares a single-ported unified memory between the instruction-fetch stage (read-only) and the load/store unit (read/write).
- Sits between the fetch stage/LSU and the memory wrapper.
- Allows one outstanding transaction at a time and routes each response back to the requester that owns it.
- LSU has priority over fetch, with a starvation limit that guarantees fetch progress; fetch redirects (branch/jump) can cancel an in-flight fetch.

Parameters:
ADDR_W, 32, address width of both requesters and the memory port
DATA_W, 32, data width; byte-enable width is DATA_W/8
MAX_LS_STREAK, 4, consecutive LSU grants allowed while fetch waits; range 1..15

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
if_req  in  1  fetch read request; held until if_gnt
if_addr  in  ADDR_W  fetch address (the PC)
if_flush  in  1  cancel the in-flight fetch; its response is dropped
if_gnt  out  1  1-cycle pulse: fetch request accepted by memory
if_rvalid  out  1  1-cycle pulse: if_rdata valid
if_rdata  out  DATA_W  instruction word
ls_req  in  1  LSU request; held until ls_gnt
ls_we  in  1  1 = store, 0 = load
ls_addr  in  ADDR_W  LSU address
ls_wdata  in  DATA_W  store data
ls_be  in  DATA_W/8  store byte enables
ls_gnt  out  1  1-cycle pulse: LSU request accepted by memory
ls_rvalid  out  1  1-cycle pulse: load data valid or store done
ls_rdata  out  DATA_W  load data
mem_req  out  1  memory request, registered
mem_we  out  1  memory write enable, registered
mem_addr  out  ADDR_W  memory address, registered
mem_wdata  out  DATA_W  memory write data, registered
mem_be  out  DATA_W/8  memory byte enables; all ones for fetch
mem_gnt  in  1  memory accepts mem_req this cycle
mem_rvalid  in  1  response valid; asserted once per accepted request, reads and writes alike
mem_rdata  in  DATA_W  memory read data

Behaviour:
Reset:
- Synchronous, active-high; also applies mid-operation.
- Clears state to IDLE, owner=NONE, ls_streak=0, drop=0.
- Clears all mem_* outputs, all gnt/rvalid outputs and both rdata outputs to 0.
- After reset, a mem_rvalid belonging to a pre-reset request arrives in IDLE and is ignored.

FSM, states IDLE, REQ, WAIT:
- IDLE: if either request is present, pick a winner, register its addr/we/wdata/be into mem_*, set mem_req=1 and owner, then go to REQ.
- Winner selection: LSU wins if ls_req=1 and (if_req=0 or ls_streak<MAX_LS_STREAK). Otherwise fetch wins.
- REQ: hold mem_req and mem_* stable until mem_gnt=1. On mem_gnt: mem_req<=0, pulse the owner's gnt (combinationally, in the same cycle as mem_gnt), go to WAIT. mem_req is never retracted before mem_gnt.
- WAIT: on mem_rvalid, drive owner rvalid=mem_rvalid and rdata=mem_rdata combinationally, then return to IDLE. A new arbitration starts in the next cycle.
- Minimum latency, requester req to rvalid: req at cycle 0, mem_req at cycle 1 (gnt same cycle), mem_rvalid at cycle 2, requester rvalid at cycle 2.
- Throughput: at most one transaction per 3 cycles.
- if_rdata/ls_rdata keep their last value when rvalid=0.

Starvation counter ls_streak (4 bits):
- +1 on each LSU grant made while if_req=1.
- Cleared on a fetch grant, or in any IDLE cycle with if_req=0.
- Saturates at MAX_LS_STREAK.

Flush:
- if_flush=1 while owner=IF in REQ or WAIT sets drop=1.
- The transaction still completes on the memory side, but if_rvalid is suppressed.
- drop clears on return to IDLE.
- if_flush in IDLE has no effect; the fetch stage re-presents the redirected PC on if_req.
- A flush in the same cycle as mem_rvalid suppresses that if_rvalid.

Simultaneous events:
- Both requests present with streak below the limit: LSU wins.
- At the limit: fetch wins.
- ls_req and if_flush are independent.

Optional Feature:
ARB_STATS_EN:
- Defined: adds outputs stat_conflicts[31:0] (IDLE cycles with if_req && ls_req) and stat_if_stall[31:0] (cycles with if_req=1 and no if_gnt).
- Both counters saturate at 32'hFFFFFFFF and are cleared by rst.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
1. rst held 2 cycles, then if_req=1, if_addr=0x00000000, memory gnt immediate and rvalid 1 cycle later with rdata=0x00000013 -> mem_req in cycle 1, if_gnt in cycle 1, if_rvalid in cycle 2 with if_rdata=0x00000013; all outputs 0 during rst.
2. if_req and ls_req held continuously, MAX_LS_STREAK=4 -> grant order LS,LS,LS,LS,IF,LS,...; ls_streak returns to 0 after the IF grant.
3. Store ls_we=1, ls_addr=0x100, ls_wdata=0xDEADBEEF, ls_be=4'b0011, mem_gnt delayed 3 cycles -> mem_* stable for all 4 REQ cycles; ls_gnt in the gnt cycle; ls_rvalid pulses once.
4. Fetch to 0x40 in WAIT, if_flush=1 -> mem_rvalid arrives but if_rvalid stays 0; next if_req to 0x80 completes normally.
5. rst asserted while in WAIT, then mem_rvalid arrives the cycle after rst drops -> no if_rvalid/ls_rvalid; state IDLE; next request serviced normally.
6. With ARB_STATS_EN, 10 cycles of simultaneous requests from reset -> stat_conflicts equals the number of IDLE cycles with both requests asserted; stat_if_stall increments every cycle fetch waits.
